shift_rows_unit: RTL and testbench

- Registered, handshaked ShiftRows / InvShiftRows stage for the AES/Rijndael datapath.
- Generalised over block width: Nb = 4, 6 or 8 columns, giving 128-, 192- or 256-bit states with Rijndael row offsets.
- Direction is selected per transfer.
- A 2-entry elastic buffer gives full throughput and decouples round logic upstream from MixColumns/AddRoundKey downstream.

---
 rtl/shift_rows_unit.sv | 83 ++++++++
 tb/tb_shift_rows_unit.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_rows_unit.sv
// ShiftRows / InvShiftRows stage for Rijndael states of 4, 6 or 8 columns.
// The permutation is applied on entry and a 2-entry FIFO holds transformed states.
module shift_rows_unit #(
   parameter int NB = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_block,
   input  logic              in_inverse,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_block,
   output logic [1:0]        occupancy
);

   localparam int W = 32 * NB;

   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("shift_rows_unit: NB must be 4, 6 or 8");
   end

   function automatic int row_shift(input int r);
      return (NB == 8 && r >= 2) ? r + 1 : r;
   endfunction

   logic [W-1:0] xf;

   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int SR = row_shift(r);
         localparam int FC = (c + SR) % NB;
         localparam int IC = (c - SR + NB) % NB;
         assign xf[W-1-(r*NB+c)*8 -: 8] = in_inverse
            ? in_block[W-1-(r*NB+IC)*8 -: 8]
            : in_block[W-1-(r*NB+FC)*8 -: 8];
      end
   end

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         push;
   logic         pop;
   logic         rd_next;
   logic [W-1:0] head_next;

   assign in_ready  = (occupancy != 2'd2) && !rst;
   assign out_valid = (occupancy != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign rd_next   = pop ? ~rd_ptr : rd_ptr;

   // out_block is its own register so the head leaves the unit with no mux
   always_comb begin
      head_next = mem[rd_next];
      if (push && wr_ptr == rd_next) head_next = xf;
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= xf;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occupancy <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         out_block <= '0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         unique case ({push, pop})
            2'b10:   occupancy <= occupancy + 2'd1;
            2'b01:   occupancy <= occupancy - 2'd1;
            default: occupancy <= occupancy;
         endcase
         out_block <= head_next;
      end
   end

endmodule

// File: tb/tb_shift_rows_unit.sv
// Randomised and directed bench for shift_rows_unit at NB = 4, 6 and 8.
// Expected states come from a queue-rotation model of the row shifts.
module tb_shift_rows_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic         v4 = 0, ir4, inv4 = 0, ov4, or4 = 1;
   logic [127:0] b4 = '0, ob4;
   logic [1:0]   occ4;

   logic         v6 = 0, ir6, inv6 = 0, ov6;
   logic [191:0] b6 = '0, ob6;
   logic [1:0]   occ6;

   logic         v8 = 0, ir8, inv8 = 0, ov8;
   logic [255:0] b8 = '0, ob8;
   logic [1:0]   occ8;

   shift_rows_unit #(.NB(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4),
      .in_block(b4), .in_inverse(inv4), .out_valid(ov4),
      .out_ready(or4), .out_block(ob4), .occupancy(occ4));

   shift_rows_unit #(.NB(6)) dut6 (
      .clk(clk), .rst(rst), .in_valid(v6), .in_ready(ir6),
      .in_block(b6), .in_inverse(inv6), .out_valid(ov6),
      .out_ready(1'b1), .out_block(ob6), .occupancy(occ6));

   shift_rows_unit #(.NB(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8),
      .in_block(b8), .in_inverse(inv8), .out_valid(ov8),
      .out_ready(1'b1), .out_block(ob8), .occupancy(occ8));

   // Rotate each row as a byte queue; state right-aligned in 256 bits
   function automatic logic [255:0] model(input int nb,
                                          input logic [255:0] blk,
                                          input logic inv);
      logic [7:0]   q[$];
      logic [255:0] res;
      int w;
      int sh;
      res = '0;
      w = 32 * nb;
      for (int r = 0; r < 4; r++) begin
         q.delete();
         for (int c = 0; c < nb; c++)
            q.push_back(blk[w-8-(r*nb+c)*8 +: 8]);
         sh = (nb == 8 && r >= 2) ? r + 1 : r;
         repeat (sh) begin
            if (inv) q.push_front(q.pop_back());
            else     q.push_back(q.pop_front());
         end
         for (int c = 0; c < nb; c++)
            res[w-8-(r*nb+c)*8 +: 8] = q[c];
      end
      return res;
   endfunction

   function automatic logic [255:0] rnd256();
      return {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++;
      if (ir4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready got=%b want=0", ir4);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (ov4 !== 1'b0 || occ4 !== 2'd0 || ob4 !== '0 || ir4 !== 1'b1) begin
         errors++;
         $display("FAIL reset_state ov=%b occ=%0d ob=%h ir=%b want 0/0/0/1",
                  ov4, occ4, ob4, ir4);
      end
   endtask

   task automatic test_directed4();
      logic [127:0] fwd;
      v4 = 1; inv4 = 1; or4 = 1;
      b4 = 128'h00010203_04050607_08090A0B_0C0D0E0F;
      tick();
      v4 = 0;
      checks++;
      if (ov4 !== 1'b1 || ob4 !== 128'h00010203_07040506_0A0B0809_0D0E0F0C) begin
         errors++;
         $display("FAIL nb4_inverse ov=%b got=%h", ov4, ob4);
      end
      v4 = 1; inv4 = 0;
      tick();
      v4 = 0;
      fwd = ob4;
      checks++;
      if (ov4 !== 1'b1 || fwd !== 128'h00010203_05060704_0A0B0809_0F0C0D0E) begin
         errors++;
         $display("FAIL nb4_forward ov=%b got=%h", ov4, fwd);
      end
      v4 = 1; inv4 = 1; b4 = fwd;
      tick();
      v4 = 0;
      checks++;
      if (ob4 !== 128'h00010203_04050607_08090A0B_0C0D0E0F) begin
         errors++;
         $display("FAIL nb4_roundtrip got=%h want=000102..0F", ob4);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0 || occ4 !== 2'd0) begin
         errors++;
         $display("FAIL nb4_drain ov=%b occ=%0d want 0/0", ov4, occ4);
      end
   endtask

   task automatic test_nb8_nb6();
      logic [255:0] exp8;
      logic [191:0] exp6;
      for (int i = 0; i < 32; i++) b8[255-i*8 -: 8] = 8'(i);
      for (int i = 0; i < 24; i++) b6[191-i*8 -: 8] = 8'(i);
      v8 = 1; inv8 = 0; v6 = 1; inv6 = 1;
      tick();
      v8 = 0; v6 = 0;
      checks++;
      if (ov8 !== 1'b1 || ob8[63:0] !== 64'h1C1D1E1F_18191A1B
          || ob8[127:64] !== 64'h13141516_17101112) begin
         errors++;
         $display("FAIL nb8_rows ov=%b r2=%h r3=%h", ov8, ob8[127:64], ob8[63:0]);
      end
      checks++;
      if (ov6 !== 1'b1 || ob6[143:96] !== 48'h0B060708090A) begin
         errors++;
         $display("FAIL nb6_row1 ov=%b got=%h want=0b060708090a", ov6, ob6[143:96]);
      end
      for (int k = 0; k < 8; k++) begin
         b8 = rnd256(); inv8 = 1'($urandom);
         b6 = 192'(rnd256()); inv6 = 1'($urandom);
         exp8 = model(8, b8, inv8);
         exp6 = 192'(model(6, {64'h0, b6}, inv6));
         v8 = 1; v6 = 1;
         tick();
         v8 = 0; v6 = 0;
         checks++;
         if (ob8 !== exp8 || ob6 !== exp6) begin
            errors++;
            $display("FAIL wide_random k=%0d nb8 got=%h want=%h nb6 got=%h want=%h",
                     k, ob8, exp8, ob6, exp6);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] a, b, ta, tb;
      a = 128'(rnd256()); b = 128'(rnd256());
      ta = 128'(model(4, {128'h0, a}, 1'b0));
      tb = 128'(model(4, {128'h0, b}, 1'b1));
      or4 = 0;
      v4 = 1; b4 = a; inv4 = 0;
      tick();
      b4 = b; inv4 = 1;
      tick();
      v4 = 0; b4 = '0;
      checks++;
      if (occ4 !== 2'd2 || ir4 !== 1'b0 || ob4 !== ta || ov4 !== 1'b1) begin
         errors++;
         $display("FAIL bp_full occ=%0d ir=%b ov=%b ob=%h want 2/0/1/%h",
                  occ4, ir4, ov4, ob4, ta);
      end
      repeat (3) begin
         tick();
         checks++;
         if (ob4 !== ta || ov4 !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold ob=%h ov=%b want %h/1", ob4, ov4, ta);
         end
      end
      or4 = 1;
      tick();
      checks++;
      if (ob4 !== tb || ov4 !== 1'b1 || ir4 !== 1'b1 || occ4 !== 2'd1) begin
         errors++;
         $display("FAIL bp_second ob=%h ov=%b ir=%b occ=%0d want %h/1/1/1",
                  ob4, ov4, ir4, occ4, tb);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0 || occ4 !== 2'd0) begin
         errors++;
         $display("FAIL bp_empty ov=%b occ=%0d want 0/0", ov4, occ4);
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] q[$];
      logic [127:0] e;
      int outs;
      outs = 0;
      or4 = 1;
      for (int i = 0; i < 18; i++) begin
         v4 = (i < 16);
         b4 = 128'(rnd256());
         inv4 = 1'(i % 2);
         if (ov4 && or4) begin
            e = q.pop_front();
            outs++;
            checks++;
            if (ob4 !== e) begin
               errors++;
               $display("FAIL stream_data i=%0d got=%h want=%h", i, ob4, e);
            end
         end
         if ((i >= 1 && i <= 16 && ov4 !== 1'b1) || occ4 === 2'd2) begin
            errors++;
            $display("FAIL stream_flow i=%0d ov=%b occ=%0d", i, ov4, occ4);
         end
         if (v4 && ir4) q.push_back(128'(model(4, {128'h0, b4}, inv4)));
         tick();
      end
      v4 = 0;
      checks++;
      if (outs != 16) begin
         errors++;
         $display("FAIL stream_count got=%0d want=16", outs);
      end
   endtask

   task automatic test_random_handshake();
      logic [127:0] q[$];
      logic [127:0] e;
      for (int i = 0; i < 300; i++) begin
         v4 = 1'($urandom_range(0, 2) != 0);
         or4 = 1'($urandom_range(0, 2) != 0);
         b4 = 128'(rnd256());
         inv4 = 1'($urandom);
         if (ov4 && or4) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious i=%0d ob=%h", i, ob4);
            end else begin
               e = q.pop_front();
               if (ob4 !== e) begin
                  errors++;
                  $display("FAIL rand_data i=%0d got=%h want=%h", i, ob4, e);
               end
            end
         end
         if (v4 && ir4) q.push_back(128'(model(4, {128'h0, b4}, inv4)));
         tick();
         checks++;
         if (occ4 !== 2'(q.size())) begin
            errors++;
            $display("FAIL rand_occ i=%0d got=%0d want=%0d", i, occ4, q.size());
         end
      end
      v4 = 0; or4 = 1;
      repeat (3) tick();
   endtask

   task automatic test_mid_reset();
      logic [127:0] n, tn;
      or4 = 0; v4 = 1;
      b4 = 128'(rnd256());
      tick();
      b4 = 128'(rnd256());
      tick();
      v4 = 0;
      checks++;
      if (occ4 !== 2'd2) begin
         errors++;
         $display("FAIL mr_fill occ=%0d want=2", occ4);
      end
      rst = 1;
      #1;
      checks++;
      if (ir4 !== 1'b0) begin
         errors++;
         $display("FAIL mr_in_ready got=%b want=0", ir4);
      end
      tick();
      rst = 0;
      #1;
      checks++;
      if (ov4 !== 1'b0 || occ4 !== 2'd0 || ob4 !== '0 || ir4 !== 1'b1) begin
         errors++;
         $display("FAIL mr_state ov=%b occ=%0d ob=%h ir=%b", ov4, occ4, ob4, ir4);
      end
      n = 128'(rnd256());
      tn = 128'(model(4, {128'h0, n}, 1'b1));
      or4 = 1; v4 = 1; b4 = n; inv4 = 1;
      tick();
      v4 = 0;
      checks++;
      if (ov4 !== 1'b1 || ob4 !== tn || occ4 !== 2'd1) begin
         errors++;
         $display("FAIL mr_fresh ov=%b ob=%h occ=%0d want 1/%h/1", ov4, ob4, occ4, tn);
      end
      tick();
      checks++;
      if (ov4 !== 1'b0) begin
         errors++;
         $display("FAIL mr_drain ov=%b want=0", ov4);
      end
   endtask

   initial begin
      #1;
      test_reset();
      test_directed4();
      test_nb8_nb6();
      test_backpressure();
      test_back_to_back();
      test_random_handshake();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
